// File: rtl/compression_ctrl.sv
// Sample sequencer for the compressor datapath: accept, settle, capture, hold. Optional COMP_BYPASS_EN adds a bypass port.
// Latency SETTLE_CYCLES+1 accept->out_valid; no skid buffer, in_ready stays low until the out_ready handshake.
module compression_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned RAMP_STEP     = 4,
    parameter logic [7:0]  RATIO_RESET   = 8'd255,
    parameter logic [7:0]  THRESH_RESET  = 8'h7F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_threshold,
    input  logic [7:0]  cfg_ratio,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] audio_in,
`ifdef COMP_BYPASS_EN
    input  logic        bypass,
`endif
    output logic [7:0]  comp_threshold,
    output logic [7:0]  comp_ratio,
    output logic [15:0] comp_audio_in,
    input  logic [15:0] comp_audio_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] audio_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [8:0] STEP9    = 9'(RAMP_STEP);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        launch_q, launch_d;
    logic [15:0] comp_audio_in_q, comp_audio_in_d;
    logic [15:0] audio_out_q, audio_out_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  comp_thr_q, comp_thr_d;
    logic [7:0]  comp_ratio_q, comp_ratio_d;
    logic [7:0]  tgt_thr_q, tgt_thr_d;
    logic [7:0]  tgt_ratio_q, tgt_ratio_d;
    logic        bypass_q, bypass_d;
    logic        bypass_in;

    logic [8:0]  cur9, tgt9, diff9, step9;
    logic [7:0]  ratio_next;

`ifdef COMP_BYPASS_EN
    assign bypass_in = bypass;
`else
    assign bypass_in = 1'b0;
`endif

    // Ratio slew toward the (possibly just-written) target, clamped so it never overshoots or wraps.
    always_comb begin
        cur9       = {1'b0, comp_ratio_q};
        tgt9       = {1'b0, tgt_ratio_d};
        diff9      = 9'd0;
        step9      = 9'd0;
        ratio_next = comp_ratio_q;
        if (tgt9 > cur9) begin
            diff9      = tgt9 - cur9;
            step9      = (diff9 < STEP9) ? diff9 : STEP9;
            ratio_next = 8'(cur9 + step9);
        end else if (tgt9 < cur9) begin
            diff9      = cur9 - tgt9;
            step9      = (diff9 < STEP9) ? diff9 : STEP9;
            ratio_next = 8'(cur9 - step9);
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        launch_d        = launch_q;
        comp_audio_in_d = comp_audio_in_q;
        audio_out_d     = audio_out_q;
        out_valid_d     = out_valid_q;
        comp_thr_d      = comp_thr_q;
        comp_ratio_d    = comp_ratio_q;
        bypass_d        = bypass_q;
        tgt_thr_d       = cfg_we ? cfg_threshold : tgt_thr_q;
        tgt_ratio_d     = cfg_we ? cfg_ratio : tgt_ratio_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    comp_audio_in_d = audio_in;
                    comp_thr_d      = tgt_thr_d;
                    bypass_d        = bypass_in;
                    cnt_d           = CNT_LOAD;
                    launch_d        = 1'b1;
                    state_d         = SETTLE;
                end
            end
            SETTLE: begin
                // First SETTLE cycle lets the freshly registered datapath inputs launch before counting.
                if (launch_q) begin
                    launch_d = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    audio_out_d = bypass_q ? comp_audio_in_q : comp_audio_out;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    comp_ratio_d = ratio_next;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= 4'd0;
            launch_q        <= 1'b0;
            comp_audio_in_q <= 16'd0;
            audio_out_q     <= 16'd0;
            out_valid_q     <= 1'b0;
            comp_thr_q      <= THRESH_RESET;
            comp_ratio_q    <= RATIO_RESET;
            tgt_thr_q       <= THRESH_RESET;
            tgt_ratio_q     <= RATIO_RESET;
            bypass_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            launch_q        <= launch_d;
            comp_audio_in_q <= comp_audio_in_d;
            audio_out_q     <= audio_out_d;
            out_valid_q     <= out_valid_d;
            comp_thr_q      <= comp_thr_d;
            comp_ratio_q    <= comp_ratio_d;
            tgt_thr_q       <= tgt_thr_d;
            tgt_ratio_q     <= tgt_ratio_d;
            bypass_q        <= bypass_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign out_valid      = out_valid_q;
    assign audio_out      = audio_out_q;
    assign comp_audio_in  = comp_audio_in_q;
    assign comp_threshold = comp_thr_q;
    assign comp_ratio     = comp_ratio_q;

endmodule

// File: tb/tb_compression_ctrl.sv
// Directed bench for compression_ctrl; datapath modelled as an arithmetic shift right by one.
module tb_compression_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_threshold = 8'h7F;
    logic [7:0]  cfg_ratio = 8'd255;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] audio_in = 16'd0;
    logic [7:0]  comp_threshold;
    logic [7:0]  comp_ratio;
    logic [15:0] comp_audio_in;
    logic [15:0] comp_audio_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] audio_out;
    logic        busy;
`ifdef COMP_BYPASS_EN
    logic        bypass = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] g_out;
    logic        g_vld;

    compression_ctrl dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_ratio(cfg_ratio),
        .in_valid(in_valid), .in_ready(in_ready), .audio_in(audio_in),
`ifdef COMP_BYPASS_EN
        .bypass(bypass),
`endif
        .comp_threshold(comp_threshold), .comp_ratio(comp_ratio), .comp_audio_in(comp_audio_in),
        .comp_audio_out(comp_audio_out), .out_valid(out_valid), .out_ready(out_ready),
        .audio_out(audio_out), .busy(busy)
    );

    always #5 clk = ~clk;
    assign comp_audio_out = {comp_audio_in[15], comp_audio_in[15:1]};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept, three settle edges, then the handshake edge with out_ready high.
    task automatic run_sample(input logic [15:0] s);
        in_valid = 1'b1; audio_in = s; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        g_out = audio_out; g_vld = out_valid;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (comp_threshold !== 8'h7F) begin n_fail++; $display("FAIL reset_thr got %h exp 7f", comp_threshold); end
        n_cmp++; if (comp_ratio !== 8'd255) begin n_fail++; $display("FAIL reset_ratio got %0d exp 255", comp_ratio); end
        n_cmp++; if (audio_out !== 16'h0000) begin n_fail++; $display("FAIL reset_audio_out got %h exp 0000", audio_out); end
        n_cmp++; if (comp_audio_in !== 16'h0000) begin n_fail++; $display("FAIL reset_comp_in got %h exp 0000", comp_audio_in); end
    endtask

    task automatic test_single;
        out_ready = 1'b1; in_valid = 1'b1; audio_in = 16'h1000;
        tick;
        in_valid = 1'b0;
        n_cmp++; if ({in_ready, busy, out_valid} !== 3'b010) begin n_fail++; $display("FAIL single_accept got rdy/busy/vld %b exp 010", {in_ready, busy, out_valid}); end
        n_cmp++; if (comp_audio_in !== 16'h1000) begin n_fail++; $display("FAIL single_comp_in got %h exp 1000", comp_audio_in); end
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_edge1_vld got %b exp 0", out_valid); end
        tick;
        n_cmp++; if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL single_edge2 got vld/rdy %b exp 00", {out_valid, in_ready}); end
        tick;
        n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL single_edge3 got vld/rdy %b exp 10", {out_valid, in_ready}); end
        n_cmp++; if (audio_out !== 16'h0800) begin n_fail++; $display("FAIL single_audio got %h exp 0800", audio_out); end
        tick;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL single_handshake got vld/rdy %b exp 01", {out_valid, in_ready}); end
    endtask

    task automatic test_backpressure;
        int xfers;
        out_ready = 1'b0; in_valid = 1'b1; audio_in = 16'h2000;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        n_cmp++; if ({out_valid, audio_out} !== {1'b1, 16'h1000}) begin n_fail++; $display("FAIL bp_capture got vld %b data %h exp 1 1000", out_valid, audio_out); end
        for (int i = 0; i < 10; i++) begin
            tick;
            n_cmp++;
            if ({out_valid, in_ready, audio_out} !== {1'b1, 1'b0, 16'h1000}) begin
                n_fail++; $display("FAIL bp_hold cycle %0d got vld/rdy %b%b data %h exp 10 1000", i, out_valid, in_ready, audio_out);
            end
        end
        out_ready = 1'b1;
        tick;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release got vld/rdy %b exp 01", {out_valid, in_ready}); end
        xfers = 0;
        repeat (6) begin tick; if (out_valid) xfers++; end
        n_cmp++; if (xfers !== 0) begin n_fail++; $display("FAIL bp_extra_xfers got %0d exp 0", xfers); end
    endtask

    task automatic test_threshold;
        in_valid = 1'b1; audio_in = 16'h0100; out_ready = 1'b1;
        tick;
        in_valid = 1'b0; cfg_we = 1'b1; cfg_threshold = 8'h20; cfg_ratio = 8'd255;
        tick;
        cfg_we = 1'b0;
        n_cmp++; if (comp_threshold !== 8'h7F) begin n_fail++; $display("FAIL thr_settle got %h exp 7f", comp_threshold); end
        repeat (3) tick;
        n_cmp++; if (comp_threshold !== 8'h7F) begin n_fail++; $display("FAIL thr_idle got %h exp 7f", comp_threshold); end
        in_valid = 1'b1; audio_in = 16'h0200;
        tick;
        in_valid = 1'b0;
        n_cmp++; if (comp_threshold !== 8'h20) begin n_fail++; $display("FAIL thr_next_accept got %h exp 20", comp_threshold); end
        repeat (4) tick;
        cfg_we = 1'b1; cfg_threshold = 8'h55; in_valid = 1'b1; audio_in = 16'h0300;
        tick;
        cfg_we = 1'b0; in_valid = 1'b0;
        n_cmp++; if (comp_threshold !== 8'h55) begin n_fail++; $display("FAIL thr_coincident got %h exp 55", comp_threshold); end
        repeat (4) tick;
        n_cmp++; if (comp_ratio !== 8'd255) begin n_fail++; $display("FAIL thr_ratio_steady got %0d exp 255", comp_ratio); end
    endtask

    task automatic test_ratio_ramp;
        logic [7:0] exp_r [4];
        exp_r[0] = 8'd251; exp_r[1] = 8'd247; exp_r[2] = 8'd245; exp_r[3] = 8'd245;
        cfg_we = 1'b1; cfg_ratio = 8'd245;
        tick;
        cfg_we = 1'b0;
        n_cmp++; if (comp_ratio !== 8'd255) begin n_fail++; $display("FAIL ramp_no_early got %0d exp 255", comp_ratio); end
        for (int i = 0; i < 4; i++) begin
            run_sample(16'h0400);
            n_cmp++; if (comp_ratio !== exp_r[i]) begin n_fail++; $display("FAIL ramp_down step %0d got %0d exp %0d", i, comp_ratio, exp_r[i]); end
        end
        cfg_we = 1'b1; cfg_ratio = 8'd2;
        tick;
        cfg_we = 1'b0;
        for (int i = 0; i < 61; i++) run_sample(16'h0010);
        n_cmp++; if (comp_ratio !== 8'd2) begin n_fail++; $display("FAIL ramp_to_2 got %0d exp 2", comp_ratio); end
        cfg_we = 1'b1; cfg_ratio = 8'd0;
        tick;
        cfg_we = 1'b0;
        run_sample(16'h0010);
        n_cmp++; if (comp_ratio !== 8'd0) begin n_fail++; $display("FAIL ramp_to_0 got %0d exp 0", comp_ratio); end
        run_sample(16'h0010);
        n_cmp++; if (comp_ratio !== 8'd0) begin n_fail++; $display("FAIL ramp_no_wrap got %0d exp 0", comp_ratio); end
    endtask

    task automatic test_cfg_on_handshake;
        out_ready = 1'b0; in_valid = 1'b1; audio_in = 16'h0040;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        cfg_we = 1'b1; cfg_ratio = 8'd100; out_ready = 1'b1;
        tick;
        cfg_we = 1'b0;
        n_cmp++; if (comp_ratio !== 8'd4) begin n_fail++; $display("FAIL cfg_handshake_ramp got %0d exp 4", comp_ratio); end
    endtask

    task automatic test_back_to_back;
        cfg_we = 1'b1; cfg_ratio = 8'd200;
        tick;
        cfg_ratio = 8'd6;
        tick;
        cfg_we = 1'b0;
        run_sample(16'h0080);
        n_cmp++; if (comp_ratio !== 8'd6) begin n_fail++; $display("FAIL b2b_cfg_last_wins got %0d exp 6", comp_ratio); end
        n_cmp++; if ({g_vld, g_out} !== {1'b1, 16'h0040}) begin n_fail++; $display("FAIL b2b_sample got vld %b data %h exp 1 0040", g_vld, g_out); end
    endtask

    task automatic test_async_reset;
        int seen;
        in_valid = 1'b1; audio_in = 16'h3000; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({in_ready, busy, out_valid} !== 3'b100) begin n_fail++; $display("FAIL areset_ctrl got rdy/busy/vld %b exp 100", {in_ready, busy, out_valid}); end
        n_cmp++; if ({comp_threshold, comp_ratio} !== {8'h7F, 8'd255}) begin n_fail++; $display("FAIL areset_cfg got %h/%0d exp 7f/255", comp_threshold, comp_ratio); end
        n_cmp++; if ({comp_audio_in, audio_out} !== 32'h0) begin n_fail++; $display("FAIL areset_data got %h/%h exp 0000/0000", comp_audio_in, audio_out); end
        tick;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin tick; if (out_valid) seen++; end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL areset_aborted_out got %0d exp 0", seen); end
        run_sample(16'h0100);
        n_cmp++; if (comp_ratio !== 8'd255) begin n_fail++; $display("FAIL areset_target got %0d exp 255", comp_ratio); end
    endtask

    task automatic test_bypass;
`ifdef COMP_BYPASS_EN
        bypass = 1'b1;
        run_sample(16'hC000);
        bypass = 1'b0;
        n_cmp++; if ({g_vld, g_out} !== {1'b1, 16'hC000}) begin n_fail++; $display("FAIL bypass_on got vld %b data %h exp 1 c000", g_vld, g_out); end
`endif
        run_sample(16'hC000);
        n_cmp++; if ({g_vld, g_out} !== {1'b1, 16'hE000}) begin n_fail++; $display("FAIL bypass_off got vld %b data %h exp 1 e000", g_vld, g_out); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_threshold;
        test_ratio_ramp;
        test_cfg_on_handshake;
        test_back_to_back;
        test_async_reset;
        test_bypass;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
